// File: rtl/cei_mochila_pkg.sv
// Shared types and constants for the external-slave guard.
//   obi_req_t / obi_resp_t   : OBI request / response bundles seen at the crossbar
//   EXT_GUARD_*              : default guard parameters
//   ext_guard_status_t       : sticky status bits {timeout, spurious}
package cei_mochila_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

    localparam int unsigned EXT_GUARD_MAX_OUTSTANDING = 2;
    localparam int unsigned EXT_GUARD_TIMEOUT_CYCLES  = 256;
    localparam logic [31:0] EXT_GUARD_ERR_RDATA       = 32'hBADC0FFE;

    typedef struct packed {
        logic timeout;
        logic spurious;
    } ext_guard_status_t;

endpackage

// File: rtl/obi_ext_guard_addr_fifo.sv
// Small address FIFO used by the guard to remember the address of every
// transaction still owed a response to the crossbar.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   push_i, data_i  write an entry
//   pop_i           drop the head entry
//   head_o          oldest entry
// The guard never pushes when full nor pops when empty; assertions watch that.
module obi_ext_guard_addr_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full, empty;

    always_comb begin
        full     = (cnt_q == CNT_W'(DEPTH));
        empty    = (cnt_q == '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        cnt_d  = cnt_q + CNT_W'(push_i) - CNT_W'(pop_i);
        head_o = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    a_no_overflow:  assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty));

endmodule

// File: rtl/obi_ext_slave_guard.sv
// Guard between the crossbar external-slave port and an external OBI slave.
// Caps outstanding transactions, answers hung transactions with a synthetic
// error response after TIMEOUT_CYCLES, and swallows the late real responses.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   slave_req_i     request from crossbar      slave_resp_o  response to crossbar
//   ext_req_o       request to external slave  ext_resp_i    response from external slave
//   clear_i         pulse, clears sticky status
//   timeout_o       sticky: a synthetic response was issued
//   spurious_o      sticky: ext rvalid arrived with nothing in flight
//   err_addr_o      address of first timed-out transaction since clear
// Optional: define OBI_EXT_GUARD_ERR_ADDR_EN to track request addresses and
// capture err_addr_o; otherwise err_addr_o is tied to 0.
module obi_ext_slave_guard
    import cei_mochila_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = EXT_GUARD_MAX_OUTSTANDING,
    parameter int unsigned TIMEOUT_CYCLES  = EXT_GUARD_TIMEOUT_CYCLES,
    parameter logic [31:0] ERR_RDATA       = EXT_GUARD_ERR_RDATA
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    slave_req_i,
    output obi_resp_t   slave_resp_o,
    output obi_req_t    ext_req_o,
    input  obi_resp_t   ext_resp_i,
    input  logic        clear_i,
    output logic        timeout_o,
    output logic        spurious_o,
    output logic [31:0] err_addr_o
);

    localparam int unsigned CNT_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W:0]    MAX_INF  = (CNT_W + 1)'(MAX_OUTSTANDING);
    localparam logic [WAIT_W-1:0] WAIT_EXP = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic              active_q;
    logic [CNT_W-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0]  drop_q, drop_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              syn_q, syn_d;
    ext_guard_status_t status_q, status_d;

    logic [CNT_W:0]    inflight;
    logic              room, accept, ext_rvalid;
    logic              swallow, fwd, spur, syn_fire, deliver;

    always_comb begin
        inflight   = {1'b0, pend_q} + {1'b0, drop_q};
        // active_q keeps both paths closed during and just after reset.
        room       = active_q && (inflight < MAX_INF);
        ext_rvalid = active_q && ext_resp_i.rvalid;
        accept     = slave_req_i.req && room && ext_resp_i.gnt;

        swallow  = ext_rvalid && (drop_q != '0);
        fwd      = ext_rvalid && (drop_q == '0) && (pend_q != '0);
        spur     = ext_rvalid && (inflight == '0);
        // A forwarded real response always wins; the synthetic one waits.
        syn_fire = syn_q && (pend_q != '0) && !fwd;
        deliver  = fwd || syn_fire;

        ext_req_o     = slave_req_i;
        ext_req_o.req = slave_req_i.req && room;

        slave_resp_o        = '0;
        slave_resp_o.gnt    = room && ext_resp_i.gnt;
        slave_resp_o.rvalid = deliver;
        if (fwd) begin
            slave_resp_o.rdata = ext_resp_i.rdata;
        end else if (syn_fire) begin
            slave_resp_o.rdata = ERR_RDATA;
        end

        pend_d = pend_q + CNT_W'(accept) - CNT_W'(deliver);
        drop_d = drop_q + CNT_W'(syn_fire) - CNT_W'(swallow);

        // The cycle of a grant (from idle) or of a delivery counts as wait 0,
        // so the synthetic response lands exactly TIMEOUT_CYCLES later.
        if (pend_d == '0) begin
            wait_d = '0;
        end else if (deliver) begin
            wait_d = WAIT_W'(1);
        end else if (syn_q) begin
            wait_d = wait_q;
        end else begin
            wait_d = wait_q + 1'b1;
        end

        if (syn_q) begin
            syn_d = !syn_fire && (pend_d != '0);
        end else begin
            syn_d = (pend_q != '0) && !deliver && (wait_q == WAIT_EXP);
        end

        status_d.timeout  = syn_fire || (status_q.timeout  && !clear_i);
        status_d.spurious = spur     || (status_q.spurious && !clear_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            pend_q   <= '0;
            drop_q   <= '0;
            wait_q   <= '0;
            syn_q    <= 1'b0;
            status_q <= '0;
        end else begin
            active_q <= 1'b1;
            pend_q   <= pend_d;
            drop_q   <= drop_d;
            wait_q   <= wait_d;
            syn_q    <= syn_d;
            status_q <= status_d;
        end
    end

    assign timeout_o  = status_q.timeout;
    assign spurious_o = status_q.spurious;

`ifdef OBI_EXT_GUARD_ERR_ADDR_EN
    logic [31:0] head_addr;
    logic [31:0] err_addr_q;

    obi_ext_guard_addr_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (32)
    ) u_addr_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (accept),
        .data_i (slave_req_i.addr),
        .pop_i  (deliver),
        .head_o (head_addr)
    );

    // Only the first timeout after a clear is recorded.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_addr_q <= '0;
        end else if (syn_fire && (!status_q.timeout || clear_i)) begin
            err_addr_q <= head_addr;
        end
    end

    assign err_addr_o = err_addr_q;
`else
    assign err_addr_o = '0;
`endif

endmodule

// File: tb/tb_obi_ext_slave_guard.sv
module tb_obi_ext_slave_guard;
    import cei_mochila_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    obi_req_t    req;
    obi_resp_t   slave_resp_o;
    obi_req_t    ext_req_o;
    obi_resp_t   eresp;
    logic        clear;
    logic        timeout_o;
    logic        spurious_o;
    logic [31:0] err_addr_o;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t e;
    int   g;

`ifdef OBI_EXT_GUARD_ERR_ADDR_EN
    localparam logic [63:0] EXP_ERR_ADDR = 64'hF000_0010;
`else
    localparam logic [63:0] EXP_ERR_ADDR = 64'h0;
`endif

    obi_ext_slave_guard dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .slave_req_i  (req),
        .slave_resp_o (slave_resp_o),
        .ext_req_o    (ext_req_o),
        .ext_resp_i   (eresp),
        .clear_i      (clear),
        .timeout_o    (timeout_o),
        .spurious_o   (spurious_o),
        .err_addr_o   (err_addr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Response monitor: every rvalid to the crossbar must match the oldest
    // expectation in both data and cycle.
    always @(negedge clk) begin
        if (rst_n && slave_resp_o.rvalid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: rdata %h at cycle %0d, want no response",
                         slave_resp_o.rdata, cyc);
            end else begin
                e = exp_q.pop_front();
                if (slave_resp_o.rdata !== e.rdata || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp_match: got rdata %h cycle %0d, want rdata %h cycle %0d",
                             slave_resp_o.rdata, cyc, e.rdata, e.cyc);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input logic [31:0] rd, input int at);
        exp_t x;
        x.rdata = rd;
        x.cyc   = at;
        exp_q.push_back(x);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        eresp = '0;
        clear = 1'b0;
        // Request and grant asserted during reset must not leak through.
        req.req    = 1'b1;
        req.addr   = 32'h1000_0000;
        eresp.gnt  = 1'b1;
        repeat (3) tick();
        chk("rst_ext_req", 64'(ext_req_o.req), 64'h0);
        chk("rst_slave_resp", 64'(slave_resp_o), 64'h0);
        chk("rst_timeout", 64'(timeout_o), 64'h0);
        chk("rst_spurious", 64'(spurious_o), 64'h0);
        chk("rst_err_addr", 64'(err_addr_o), 64'h0);
        req   = '0;
        eresp = '0;
        rst_n = 1'b1;
        tick();
        tick();

        // Single read answered three cycles after the grant.
        req.req   = 1'b1;
        req.addr  = 32'h0000_1000;
        eresp.gnt = 1'b1;
        #1;
        chk("t1_gnt", 64'(slave_resp_o.gnt), 64'h1);
        chk("t1_ext_req", 64'(ext_req_o.req), 64'h1);
        chk("t1_ext_addr", 64'(ext_req_o.addr), 64'h1000);
        g = cyc;
        expect_resp(32'h1234_5678, g + 3);
        tick();
        req = '0;
        eresp.gnt = 1'b0;
        tick();
        tick();
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h1234_5678;
        tick();
        eresp = '0;
        tick();
        chk("t1_timeout", 64'(timeout_o), 64'h0);
        chk("t1_spurious", 64'(spurious_o), 64'h0);

        // Outstanding limit: third request blocked until a response retires.
        eresp.gnt = 1'b1;
        req.req   = 1'b1;
        req.addr  = 32'h2000;
        tick();
        req.addr  = 32'h2004;
        tick();
        req.addr  = 32'h2008;
        #1;
        chk("t2_gnt_full", 64'(slave_resp_o.gnt), 64'h0);
        chk("t2_ext_req_full", 64'(ext_req_o.req), 64'h0);
        tick();
        chk("t2_gnt_full2", 64'(slave_resp_o.gnt), 64'h0);
        tick();
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h0000_00A1;
        expect_resp(32'h0000_00A1, cyc);
        #1;
        chk("t2_no_bypass_gnt", 64'(slave_resp_o.gnt), 64'h0);
        chk("t2_no_bypass_req", 64'(ext_req_o.req), 64'h0);
        tick();
        eresp.rvalid = 1'b0;
        #1;
        chk("t2_gnt_after", 64'(slave_resp_o.gnt), 64'h1);
        chk("t2_ext_req_after", 64'(ext_req_o.req), 64'h1);
        chk("t2_ext_addr_after", 64'(ext_req_o.addr), 64'h2008);
        tick();
        req = '0;
        eresp.gnt    = 1'b0;
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h0000_00A2;
        expect_resp(32'h0000_00A2, cyc);
        tick();
        eresp.rdata  = 32'h0000_00A3;
        expect_resp(32'h0000_00A3, cyc);
        tick();
        eresp = '0;
        tick();

        // Silent slave: synthetic error exactly 256 cycles after the grant.
        req.req   = 1'b1;
        req.addr  = 32'hF000_0010;
        eresp.gnt = 1'b1;
        g = cyc;
        expect_resp(32'hBADC_0FFE, g + 256);
        tick();
        req = '0;
        eresp.gnt = 1'b0;
        repeat (254) tick();
        chk("t3_timeout_pre", 64'(timeout_o), 64'h0);
        tick();
        chk("t3_syn_rvalid", 64'(slave_resp_o.rvalid), 64'h1);
        chk("t3_syn_rdata", 64'(slave_resp_o.rdata), 64'hBADC_0FFE);
        tick();
        chk("t3_timeout", 64'(timeout_o), 64'h1);
        chk("t3_err_addr", 64'(err_addr_o), EXP_ERR_ADDR);

        // Late real response is swallowed; next transaction is normal.
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'hDEAD_BEEF;
        #1;
        chk("t4_late_swallowed", 64'(slave_resp_o.rvalid), 64'h0);
        tick();
        eresp = '0;
        tick();
        chk("t4_no_spurious", 64'(spurious_o), 64'h0);
        chk("t4_timeout_sticky", 64'(timeout_o), 64'h1);
        req.req   = 1'b1;
        req.addr  = 32'h3000;
        eresp.gnt = 1'b1;
        expect_resp(32'hCAFE_0001, cyc + 1);
        tick();
        req = '0;
        eresp.gnt    = 1'b0;
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'hCAFE_0001;
        tick();
        eresp = '0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t4_timeout_cleared", 64'(timeout_o), 64'h0);

        // Real response in the cycle the timer reaches 255 beats the timeout.
        req.req   = 1'b1;
        req.addr  = 32'h4000;
        eresp.gnt = 1'b1;
        g = cyc;
        expect_resp(32'h55AA_55AA, g + 255);
        tick();
        req = '0;
        eresp.gnt = 1'b0;
        repeat (254) tick();
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h55AA_55AA;
        tick();
        eresp = '0;
        repeat (3) tick();
        chk("t5_timeout", 64'(timeout_o), 64'h0);

        // Spurious response, set-over-clear priority, then clear.
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h0000_0099;
        #1;
        chk("t6_spur_not_fwd", 64'(slave_resp_o.rvalid), 64'h0);
        tick();
        eresp = '0;
        chk("t6_spurious", 64'(spurious_o), 64'h1);
        eresp.rvalid = 1'b1;
        clear = 1'b1;
        tick();
        eresp = '0;
        clear = 1'b0;
        chk("t6_set_over_clear", 64'(spurious_o), 64'h1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t6_spurious_clr", 64'(spurious_o), 64'h0);
        chk("t6_timeout_clr", 64'(timeout_o), 64'h0);

        // Reset mid-transaction, then a late response for the lost transaction.
        eresp.rvalid = 1'b1;
        tick();
        eresp = '0;
        req.req   = 1'b1;
        req.addr  = 32'h5000;
        eresp.gnt = 1'b1;
        tick();
        #1;
        chk("t7_pre_rst_req", 64'(ext_req_o.req), 64'h1);
        chk("t7_pre_rst_spur", 64'(spurious_o), 64'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_ext_req", 64'(ext_req_o.req), 64'h0);
        chk("t7_rst_resp", 64'(slave_resp_o), 64'h0);
        chk("t7_rst_spurious", 64'(spurious_o), 64'h0);
        chk("t7_rst_err_addr", 64'(err_addr_o), 64'h0);
        req   = '0;
        eresp = '0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        eresp.rvalid = 1'b1;
        eresp.rdata  = 32'h0000_0077;
        #1;
        chk("t7_post_rst_not_fwd", 64'(slave_resp_o.rvalid), 64'h0);
        tick();
        eresp = '0;
        chk("t7_post_rst_spurious", 64'(spurious_o), 64'h1);

        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL resp_missing: %0d expected responses never seen, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
